// File: rtl/alu_writeback_stage_if.sv
// Purpose : operand/control bundle and write-back results of the AR/T execute slice.
// Latency : wires only; the stage behind it registers write-back one cycle later.
// Backpressure: none; the stage consumes a new operand set every cycle.
// Ports   : master = decode/regfile side (drives operands, controls; sees results),
//           slave  = alu_writeback_stage (consumes operands, drives results).
interface alu_writeback_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
);
    logic [DATA_W-1:0] alu_inputA;
    logic [DATA_W-1:0] alu_inputB;
    logic [3:0]        alu_control;
    logic [REG_W-1:0]  rd_ar;
    logic [REG_W-1:0]  rd_t;
    logic [DATA_W-1:0] ext_data;
    logic              C_ART_reg;
    logic              C_ART_data;
    logic              regWrite_in;

    logic [DATA_W-1:0] alu_output;
    logic              alu_cout;
    logic [REG_W-1:0]  writeReg;
    logic [DATA_W-1:0] writeData;
    logic              regWrite;
    logic              zero_q;
    logic              ovf_q;

    modport master (
        output alu_inputA, alu_inputB, alu_control, rd_ar, rd_t, ext_data,
               C_ART_reg, C_ART_data, regWrite_in,
        input  alu_output, alu_cout, writeReg, writeData, regWrite, zero_q, ovf_q
    );

    modport slave (
        input  alu_inputA, alu_inputB, alu_control, rd_ar, rd_t, ext_data,
               C_ART_reg, C_ART_data, regWrite_in,
        output alu_output, alu_cout, writeReg, writeData, regWrite, zero_q, ovf_q
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// Purpose : 32-bit ALU plus destination/data select, registered for register-file write-back.
// Latency : alu_output/alu_cout combinational; writeReg/writeData/regWrite/zero_q/ovf_q 1 cycle.
// Backpressure: none; the output register loads on every CLK edge while RESET is high.
// Ports   : CLK (rising edge), RESET (async, active low), io (slave side of
//           alu_writeback_stage_if: operands, ALU op, rd fields, selects, results).
module alu_writeback_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    alu_writeback_stage_if.slave  io
);
    localparam int MSB = DATA_W - 1;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b0110;
    localparam logic [3:0] OP_SRL   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_SLT   = 4'b1001;
    localparam logic [3:0] OP_SLTU  = 4'b1010;
    localparam logic [3:0] OP_NOT   = 4'b1011;
    localparam logic [3:0] OP_PASSB = 4'b1100;
    localparam logic [3:0] OP_PASSA = 4'b1101;
    localparam logic [3:0] OP_INC   = 4'b1110;

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        shamt;
    logic [DATA_W:0]   add_sum;
    logic [DATA_W:0]   sub_sum;
    logic [DATA_W:0]   inc_sum;
    logic [DATA_W-1:0] alu_res;
    logic              cout;
    logic              ovf;
    logic [REG_W-1:0]  mux_reg;
    logic [DATA_W-1:0] mux_data;

    assign a     = io.alu_inputA;
    assign b     = io.alu_inputB;
    assign shamt = b[4:0];

    // One extra bit on each adder captures the carry out of bit MSB.
    // SUB is A + ~B + 1, so its carry is the "no borrow" flag.
    assign add_sum = {1'b0, a} + {1'b0, b};
    assign sub_sum = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
    assign inc_sum = {1'b0, a} + (DATA_W+1)'(1);

    always_comb begin
        alu_res = '0;
        cout    = 1'b0;
        ovf     = 1'b0;
        case (io.alu_control)
            OP_ADD: begin
                alu_res = add_sum[MSB:0];
                cout    = add_sum[DATA_W];
                ovf     = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res = sub_sum[MSB:0];
                cout    = sub_sum[DATA_W];
                ovf     = (a[MSB] != b[MSB]) && (sub_sum[MSB] != a[MSB]);
            end
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_XOR:   alu_res = a ^ b;
            OP_NOR:   alu_res = ~(a | b);
            OP_SLL:   alu_res = a << shamt;
            OP_SRL:   alu_res = a >> shamt;
            OP_SRA:   alu_res = DATA_W'($signed(a) >>> shamt);
            OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  alu_res = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_NOT:   alu_res = ~a;
            OP_PASSB: alu_res = b;
            OP_PASSA: alu_res = a;
            OP_INC: begin
                alu_res = inc_sum[MSB:0];
                cout    = inc_sum[DATA_W];
                // Only the largest positive value wraps to negative on +1.
                ovf     = (a == {1'b0, {(DATA_W-1){1'b1}}});
            end
            default:  alu_res = '0;
        endcase
    end

    assign io.alu_output = alu_res;
    assign io.alu_cout   = cout;

    assign mux_reg  = io.C_ART_reg  ? io.rd_t     : io.rd_ar;
    assign mux_data = io.C_ART_data ? io.ext_data : alu_res;

    // zero_q follows the ALU result, not the selected write data.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            io.writeReg  <= '0;
            io.writeData <= '0;
            io.regWrite  <= 1'b0;
            io.zero_q    <= 1'b0;
            io.ovf_q     <= 1'b0;
        end else begin
            io.writeReg  <= mux_reg;
            io.writeData <= mux_data;
            io.regWrite  <= io.regWrite_in;
            io.zero_q    <= (alu_res == '0);
            io.ovf_q     <= ovf;
        end
    end
endmodule

// File: tb/tb_alu_writeback_stage.sv
module tb_alu_writeback_stage;
    logic CLK;
    logic RESET;
    int   n_cmp;
    int   n_err;

    alu_writeback_stage_if #(.DATA_W(32), .REG_W(4)) bus ();

    alu_writeback_stage #(.DATA_W(32), .REG_W(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .io    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.alu_control = op;
        bus.alu_inputA  = a;
        bus.alu_inputB  = b;
    endtask

    task automatic sel(input logic cr, input logic cd, input logic [3:0] ar,
                       input logic [3:0] t, input logic [31:0] ext, input logic we);
        bus.C_ART_reg   = cr;
        bus.C_ART_data  = cd;
        bus.rd_ar       = ar;
        bus.rd_t        = t;
        bus.ext_data    = ext;
        bus.regWrite_in = we;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset held from time 0 with nonzero inputs, checked before any rising edge.
        RESET = 1'b0;
        drive(4'b0000, 32'h11, 32'h22);
        sel(1'b0, 1'b0, 4'd3, 4'd7, 32'hDEAD_BEEF, 1'b1);
        #2;
        chk("rst_writeReg",  32'(bus.writeReg), 32'h0);
        chk("rst_writeData", bus.writeData, 32'h0);
        chk("rst_regWrite",  32'(bus.regWrite), 32'h0);
        chk("rst_zero_q",    32'(bus.zero_q), 32'h0);
        chk("rst_ovf_q",     32'(bus.ovf_q), 32'h0);
        chk("rst_alu_comb",  bus.alu_output, 32'h33);
        @(posedge CLK); #1;
        chk("rst_hold_writeData", bus.writeData, 32'h0);

        // Release, first load on the next rising edge.
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;
        chk("load_writeData", bus.writeData, 32'h33);
        chk("load_writeReg",  32'(bus.writeReg), 32'd3);
        chk("load_regWrite",  32'(bus.regWrite), 32'h1);

        // ADD wrap.
        @(negedge CLK);
        drive(4'b0000, 32'hFFFF_FFFF, 32'h1);
        sel(1'b0, 1'b0, 4'd5, 4'd7, 32'h0, 1'b1);
        #1;
        chk("addwrap_out",  bus.alu_output, 32'h0);
        chk("addwrap_cout", 32'(bus.alu_cout), 32'h1);
        @(posedge CLK); #1;
        chk("addwrap_writeData", bus.writeData, 32'h0);
        chk("addwrap_writeReg",  32'(bus.writeReg), 32'd5);
        chk("addwrap_zero_q",    32'(bus.zero_q), 32'h1);
        chk("addwrap_regWrite",  32'(bus.regWrite), 32'h1);
        chk("addwrap_ovf_q",     32'(bus.ovf_q), 32'h0);

        // ADD signed overflow.
        @(negedge CLK);
        drive(4'b0000, 32'h7FFF_FFFF, 32'h1);
        #1;
        chk("addovf_out",  bus.alu_output, 32'h8000_0000);
        chk("addovf_cout", 32'(bus.alu_cout), 32'h0);
        @(posedge CLK); #1;
        chk("addovf_ovf_q",  32'(bus.ovf_q), 32'h1);
        chk("addovf_zero_q", 32'(bus.zero_q), 32'h0);

        // SUB signed overflow, no borrow; write disabled this cycle.
        @(negedge CLK);
        drive(4'b0001, 32'h8000_0000, 32'h1);
        bus.regWrite_in = 1'b0;
        #1;
        chk("subovf_out",  bus.alu_output, 32'h7FFF_FFFF);
        chk("subovf_cout", 32'(bus.alu_cout), 32'h1);
        @(posedge CLK); #1;
        chk("subovf_ovf_q",    32'(bus.ovf_q), 32'h1);
        chk("subovf_regWrite", 32'(bus.regWrite), 32'h0);

        // SUB with borrow: 1 - 2.
        @(negedge CLK);
        drive(4'b0001, 32'h1, 32'h2);
        #1;
        chk("subbor_out",  bus.alu_output, 32'hFFFF_FFFF);
        chk("subbor_cout", 32'(bus.alu_cout), 32'h0);

        // T path: destination and data from the T fields.
        @(negedge CLK);
        drive(4'b0000, 32'h3, 32'h3);
        sel(1'b1, 1'b1, 4'd2, 4'd9, 32'hFFFC_0000, 1'b1);
        #1;
        chk("tpath_alu", bus.alu_output, 32'h6);
        @(posedge CLK); #1;
        chk("tpath_writeReg",  32'(bus.writeReg), 32'd9);
        chk("tpath_writeData", bus.writeData, 32'hFFFC_0000);
        chk("tpath_zero_q",    32'(bus.zero_q), 32'h0);

        // T data with zero ALU result: zero_q follows the ALU, not ext_data.
        @(negedge CLK);
        drive(4'b1111, 32'h3, 32'h3);
        @(posedge CLK); #1;
        chk("tzero_zero_q", 32'(bus.zero_q), 32'h1);

        // Shifts with B upper bits set (amount = 4) and compares.
        @(negedge CLK);
        sel(1'b0, 1'b0, 4'd1, 4'd0, 32'h0, 1'b1);
        drive(4'b1000, 32'h8000_0000, 32'h24); #1;
        chk("sra_out",  bus.alu_output, 32'hF800_0000);
        chk("sra_cout", 32'(bus.alu_cout), 32'h0);
        drive(4'b0111, 32'h8000_0000, 32'h24); #1;
        chk("srl_out", bus.alu_output, 32'h0800_0000);
        drive(4'b0110, 32'h8000_0000, 32'h24); #1;
        chk("sll_out", bus.alu_output, 32'h0);
        drive(4'b1001, 32'hFFFF_FFFF, 32'h1); #1;
        chk("slt_out", bus.alu_output, 32'h1);
        drive(4'b1010, 32'hFFFF_FFFF, 32'h1); #1;
        chk("sltu_out", bus.alu_output, 32'h0);

        // Remaining logic ops.
        drive(4'b0101, 32'hF0F0, 32'hFF00); #1;
        chk("nor_out", bus.alu_output, 32'hFFFF_000F);
        drive(4'b1011, 32'h1234_5678, 32'h0); #1;
        chk("not_out", bus.alu_output, 32'hEDCB_A987);
        drive(4'b1100, 32'h1, 32'hCAFE_F00D); #1;
        chk("passb_out", bus.alu_output, 32'hCAFE_F00D);
        drive(4'b1101, 32'h1234_5678, 32'h9); #1;
        chk("passa_out", bus.alu_output, 32'h1234_5678);

        // INC boundaries.
        drive(4'b1110, 32'hFFFF_FFFF, 32'h0); #1;
        chk("incwrap_out",  bus.alu_output, 32'h0);
        chk("incwrap_cout", 32'(bus.alu_cout), 32'h1);
        @(posedge CLK); #1;
        chk("incwrap_ovf_q", 32'(bus.ovf_q), 32'h0);
        @(negedge CLK);
        drive(4'b1110, 32'h7FFF_FFFF, 32'h0); #1;
        chk("incovf_out",  bus.alu_output, 32'h8000_0000);
        chk("incovf_cout", 32'(bus.alu_cout), 32'h0);
        @(posedge CLK); #1;
        chk("incovf_ovf_q", 32'(bus.ovf_q), 32'h1);

        // Back-to-back: each result lands exactly one edge after its inputs.
        @(negedge CLK);
        drive(4'b0010, 32'hF0F0, 32'hFF00);
        @(posedge CLK); #1;
        chk("b2b_and", bus.writeData, 32'hF000);
        @(negedge CLK);
        drive(4'b0011, 32'hF0F0, 32'hFF00); #1;
        chk("b2b_and_hold", bus.writeData, 32'hF000);
        @(posedge CLK); #1;
        chk("b2b_or", bus.writeData, 32'hFFF0);
        @(negedge CLK);
        drive(4'b0100, 32'hF0F0, 32'hFF00);
        @(posedge CLK); #1;
        chk("b2b_xor", bus.writeData, 32'h0FF0);

        // Mid-operation reset: outputs clear at once, no write survives.
        @(negedge CLK);
        sel(1'b0, 1'b0, 4'd6, 4'd0, 32'h0, 1'b1);
        drive(4'b0000, 32'h5, 32'h5);
        @(posedge CLK); #1;
        chk("mid_pre_writeData", bus.writeData, 32'hA);
        #2;
        RESET = 1'b0;
        #1;
        chk("mid_writeData", bus.writeData, 32'h0);
        chk("mid_writeReg",  32'(bus.writeReg), 32'h0);
        chk("mid_regWrite",  32'(bus.regWrite), 32'h0);
        @(posedge CLK); #1;
        chk("mid_hold_regWrite", 32'(bus.regWrite), 32'h0);
        chk("mid_alu_comb",      bus.alu_output, 32'hA);
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;
        chk("mid_reload_writeData", bus.writeData, 32'hA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
Execute/write-back slice of the single-cycle AR/T processor datapath. It combines three functions:
- a 4-bit-controlled 32-bit ALU;
- a 4-bit 2:1 mux selecting the destination register (AR rd field vs T rd field);
- a 32-bit 2:1 mux selecting the write data (ALU result vs sign-extended T constant).

Results are registered once so the register file receives stable write-back values on the next CLK edge.

Parameters:
- DATA_W, 32, ALU/write-data width.
- REG_W, 4, register-index width.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
- alu_inputA  input  32  operand A (register file read port 1).
- alu_inputB  input  32  operand B (register file read port 2).
- alu_control  input  4  ALU operation select (from aluControl_unit).
- rd_ar  input  4  AR destination field, instr[14:11].
- rd_t  input  4  T destination field, instr[22:19].
- ext_data  input  32  sign-extended T constant.
- C_ART_reg  input  1  destination select: 0 = rd_ar, 1 = rd_t.
- C_ART_data  input  1  data select: 0 = ALU result, 1 = ext_data.
- regWrite_in  input  1  write enable from control unit.
- alu_output  output  32  combinational ALU result.
- alu_cout  output  1  combinational carry out.
- writeReg  output  4  registered destination index.
- writeData  output  32  registered write data.
- regWrite  output  1  registered write enable.
- zero_q  output  1  registered flag, (alu_output == 0).
- ovf_q  output  1  registered signed overflow flag.

Behaviour:
ALU (combinational), selected by alu_control:
- 0000 ADD: A+B; alu_cout = carry out of bit 31.
- 0001 SUB: A-B computed as A+~B+1; alu_cout = carry (1 means no borrow, i.e. A >= B unsigned).
- 0010 AND, 0011 OR, 0100 XOR, 0101 NOR.
- 0110 SLL: A << B[4:0].
- 0111 SRL: logical A >> B[4:0].
- 1000 SRA: arithmetic A >>> B[4:0].
- 1001 SLT: 1 if A < B signed, else 0.
- 1010 SLTU: 1 if A < B unsigned, else 0.
- 1011 NOT: ~A.
- 1100 PASSB: B.
- 1101 PASSA: A.
- 1110 INC: A+1, with carry out.
- 1111: result 0.
- alu_cout is 0 for every op except ADD, SUB and INC.
- Overflow (ADD/INC/SUB only): set when operand signs make the result sign wrong. ADD: A[31]==B[31] and result sign differs. SUB: A[31]!=B[31] and result sign differs from A[31]. INC: A == 0x7FFFFFFF. All other ops: 0.

Muxes (combinational):
- mux_reg = C_ART_reg ? rd_t : rd_ar.
- mux_data = C_ART_data ? ext_data : alu_output.
- No X-propagation tricks; a plain 2:1 select.

Registers:
- On CLK rising edge, load writeReg <= mux_reg, writeData <= mux_data, regWrite <= regWrite_in, zero_q, ovf_q.
- Latency from inputs to registered outputs is exactly 1 cycle. No stall or hold; the stage loads every cycle.
- RESET low forces writeReg = 0, writeData = 0, regWrite = 0, zero_q = 0, ovf_q = 0 immediately, with no clock needed.
- Outputs hold 0 while RESET is low. The first load happens on the first rising edge after RESET goes high.
- RESET asserted mid-operation discards any in-flight result; no write is issued.
- alu_output and alu_cout are combinational and unaffected by reset.
- zero_q reflects the ALU result even when C_ART_data = 1.

Width rules:
- All arithmetic is modulo 2^32.
- Shift amounts use B[4:0] only; upper bits of B are ignored.

Test Plan:
- Reset: drive RESET=0 with nonzero inputs, no clock edge -> writeReg=0, writeData=0, regWrite=0, zero_q=0, ovf_q=0. Release and clock once -> registered outputs load.
- ADD wrap: A=0xFFFFFFFF, B=0x00000001, ctrl=0000, C_ART_data=0, rd_ar=5, C_ART_reg=0, regWrite_in=1 -> alu_output=0, alu_cout=1. After edge: writeData=0, writeReg=5, zero_q=1, regWrite=1, ovf_q=0.
- Signed overflow: A=0x7FFFFFFF, B=1, ADD -> alu_output=0x80000000, cout=0, ovf_q=1 after edge. SUB with A=0x80000000, B=1 -> 0x7FFFFFFF, cout=1, ovf_q=1.
- T path: C_ART_reg=1, C_ART_data=1, rd_t=9, ext_data=0xFFFC0000, A=B=3, ADD -> writeReg=9, writeData=0xFFFC0000 after one edge; zero_q=0 (ALU result 6).
- Shifts/compares: A=0x80000000, B=0x24 (shift 4). SRA -> 0xF8000000; SRL -> 0x08000000; SLL -> 0. SLT with A=-1, B=1 -> 1; SLTU with the same operands -> 0.
- Back-to-back: change ctrl every cycle (AND 0xF0F0&0xFF00=0xF000, OR=0xFFF0, XOR=0x0FF0). Each registered writeData appears exactly one cycle after its inputs.
